// File: rtl/hazard_unit.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: scoreboard, load-use stalls,
// registered forwarding selects, multi-cycle EX hold and redirect flushes. Optional: `HAZARD_FWD_EN.
module hazard_unit #(
  parameter int AW           = 5,
  parameter int MC_CNT_W     = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [AW-1:0]       id_rs1,
  input  logic                id_rs1_used,
  input  logic [AW-1:0]       id_rs2,
  input  logic                id_rs2_used,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_we,
  input  logic                id_is_load,
  input  logic                id_mc,
  input  logic [MC_CNT_W-1:0] id_mc_cycles,
  input  logic                ex_redirect,
  output logic                stall_if,
  output logic                stall_id,
  output logic                bubble_ex,
  output logic                flush_id,
  output logic [1:0]          fwd_rs1_sel,
  output logic [1:0]          fwd_rs2_sel,
  output logic                busy
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          we;
    logic          load;
  } sb_entry_t;

  sb_entry_t           ex_q, mem_q, wb_q;
  logic [MC_CNT_W-1:0] mc_cnt;
  logic [FC_W-1:0]     flush_cnt;
  logic [1:0]          fwd1_q, fwd2_q;

  function automatic logic hit(input sb_entry_t e, input logic [AW-1:0] rs, input logic used,
                               input logic valid_id);
    return e.valid && e.we && (e.rd != '0) && (e.rd == rs) && used && valid_id;
  endfunction

  logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
  logic mc_active, flush_active, redirect_take, flush_now;
  logic hazard, hold_id, advance;
  logic [1:0] fwd1_d, fwd2_d;

  assign rs1_ex  = hit(ex_q,  id_rs1, id_rs1_used, id_valid);
  assign rs2_ex  = hit(ex_q,  id_rs2, id_rs2_used, id_valid);
  assign rs1_mem = hit(mem_q, id_rs1, id_rs1_used, id_valid);
  assign rs2_mem = hit(mem_q, id_rs2, id_rs2_used, id_valid);

  assign mc_active     = (mc_cnt != '0);
  assign flush_active  = (flush_cnt != '0);
  assign redirect_take = ex_redirect && !mc_active;
  assign flush_now     = redirect_take || flush_active;

`ifdef HAZARD_FWD_EN
  assign hazard = (rs1_ex || rs2_ex) && ex_q.load;
`else
  // Without forwarding a consumer waits until its producer has reached WB.
  assign hazard = rs1_ex || rs2_ex || rs1_mem || rs2_mem;
`endif

  // A flushed ID slot is discarded, so a hazard on it must not stall fetch of the new target.
  assign hold_id = mc_active || (hazard && !flush_now);
  assign advance = id_valid && !hold_id && !flush_now;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fwd1_d = 2'd0;
    fwd2_d = 2'd0;
`ifdef HAZARD_FWD_EN
    if (rs1_ex && !ex_q.load) fwd1_d = 2'd1;
    else if (rs1_mem)         fwd1_d = 2'd2;
    if (rs2_ex && !ex_q.load) fwd2_d = 2'd1;
    else if (rs2_mem)         fwd2_d = 2'd2;
`endif
  end

  assign stall_if    = !rst && hold_id;
  assign stall_id    = !rst && hold_id;
  assign bubble_ex   = !rst && !mc_active && (hazard || flush_now);
  assign flush_id    = !rst && flush_now;
  assign busy        = !rst && mc_active;
  assign fwd_rs1_sel = fwd1_q;
  assign fwd_rs2_sel = fwd2_q;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      mc_cnt    <= '0;
      flush_cnt <= '0;
      fwd1_q    <= 2'd0;
      fwd2_q    <= 2'd0;
    end else begin
      wb_q <= mem_q;
      if (mc_active) begin
        mem_q  <= '0;
        mc_cnt <= mc_cnt - MC_CNT_W'(1);
      end else begin
        mem_q <= ex_q;
        ex_q  <= advance ? '{valid: 1'b1, rd: id_rd, we: id_we, load: id_is_load} : '0;
        if (advance && id_mc)
          mc_cnt <= (id_mc_cycles == '0) ? '0 : id_mc_cycles - MC_CNT_W'(1);
      end

      if (redirect_take)     flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
      else if (flush_active) flush_cnt <= flush_cnt - FC_W'(1);

      if (advance) begin
        fwd1_q <= fwd1_d;
        fwd2_q <= fwd2_d;
      end
    end
  end

  // WB producers are served by the falling-edge regfile write; the entry is tracked for completeness.
  logic unused_sb;
  assign unused_sb = ^{wb_q, mem_q.load, ex_q.load};

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed test-plan scenarios followed by random traffic,
// all checked against a timestamp-based model of instructions in flight.
module tb_hazard_unit;

  localparam int AW           = 5;
  localparam int MCW          = 6;
  localparam int FLUSH_CYCLES = 2;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, id_mc, ex_redirect;
  logic [AW-1:0]  id_rs1, id_rs2, id_rd;
  logic [MCW-1:0] id_mc_cycles;
  logic           stall_if, stall_id, bubble_ex, flush_id, busy;
  logic [1:0]     fwd_rs1_sel, fwd_rs2_sel;

  hazard_unit #(.AW(AW), .MC_CNT_W(MCW), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_mc(id_mc),
    .id_mc_cycles(id_mc_cycles), .ex_redirect(ex_redirect),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; logic [AW-1:0] rs1; bit u1; logic [AW-1:0] rs2; bit u2;
    logic [AW-1:0] rd; bit we; bit ld; bit mc; logic [MCW-1:0] mcc;
  } op_t;

  // An issued instruction occupies EX for cycles [start, start+len-1], then MEM, then WB.
  typedef struct { int start; int len; logic [AW-1:0] rd; bit we; bit ld; } flight_t;

  flight_t    fl[$];
  int         cyc, last_red;
  logic [1:0] m_fwd1, m_fwd2;
  int         n_pass = 0, n_total = 0;
  int         cnt_stall, cnt_busy, cnt_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit in_ex(input flight_t f, input int c);
    return c >= f.start && c < f.start + f.len;
  endfunction

  function automatic bit in_mem(input flight_t f, input int c);
    return c == f.start + f.len;
  endfunction

  function automatic bit m_busy(input int c);
    foreach (fl[i]) if (c >= fl[i].start && c < fl[i].start + fl[i].len - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit feeds(input flight_t f, input logic [AW-1:0] rs, input bit used);
    return used && f.we && f.rd != '0 && f.rd == rs;
  endfunction

  function automatic bit needs_stall(input logic [AW-1:0] rs, input bit used, input int c);
    foreach (fl[i]) if (feeds(fl[i], rs, used)) begin
      if (FWD) begin
        if (in_ex(fl[i], c) && fl[i].ld) return 1'b1;
      end else if (in_ex(fl[i], c) || in_mem(fl[i], c)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_src(input logic [AW-1:0] rs, input bit used, input int c);
    logic [1:0] s = 2'd0;
    foreach (fl[i]) if (feeds(fl[i], rs, used)) begin
      if (in_ex(fl[i], c) && !fl[i].ld) return 2'd1;
      if (in_mem(fl[i], c)) s = 2'd2;
    end
    return s;
  endfunction

  function automatic op_t mk(input int rd, input int rs1, input bit u1, input int rs2, input bit u2,
                             input bit we, input bit ld, input bit mc, input int mcc);
    op_t o;
    o.v = 1'b1; o.rd = AW'(rd); o.rs1 = AW'(rs1); o.u1 = u1; o.rs2 = AW'(rs2); o.u2 = u2;
    o.we = we; o.ld = ld; o.mc = mc; o.mcc = MCW'(mcc);
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.v   = ($urandom_range(0, 9) < 8);
    o.rd  = AW'($urandom_range(0, 3));
    o.rs1 = AW'($urandom_range(0, 3));
    o.rs2 = AW'($urandom_range(0, 3));
    o.u1  = $urandom_range(0, 1) == 1;
    o.u2  = $urandom_range(0, 1) == 1;
    o.we  = ($urandom_range(0, 9) < 7);
    o.ld  = ($urandom_range(0, 3) == 0);
    o.mc  = ($urandom_range(0, 9) == 0);
    o.mcc = MCW'($urandom_range(0, 5));
    return o;
  endfunction

  task automatic model_reset();
    fl.delete();
    m_fwd1   = 2'd0;
    m_fwd2   = 2'd0;
    last_red = -1000;
  endtask

  task automatic drive(input op_t o, input bit red);
    id_valid = o.v; id_rs1 = o.rs1; id_rs1_used = o.u1; id_rs2 = o.rs2; id_rs2_used = o.u2;
    id_rd = o.rd; id_we = o.we; id_is_load = o.ld; id_mc = o.mc; id_mc_cycles = o.mcc;
    ex_redirect = red;
  endtask

  task automatic check_zero(input string p);
    check({p, "_stall_if"},  32'(stall_if),    32'd0);
    check({p, "_stall_id"},  32'(stall_id),    32'd0);
    check({p, "_bubble_ex"}, 32'(bubble_ex),   32'd0);
    check({p, "_flush_id"},  32'(flush_id),    32'd0);
    check({p, "_busy"},      32'(busy),        32'd0);
    check({p, "_fwd1"},      32'(fwd_rs1_sel), 32'd0);
    check({p, "_fwd2"},      32'(fwd_rs2_sel), 32'd0);
  endtask

  // One clock cycle: drive ID, predict and compare all outputs, then advance the model.
  task automatic step(input op_t o, input bit red, output bit adv);
    bit busy_e, red_eff, flush_e, haz, stall_e, bub_e;
    drive(o, red);
    #1;
    busy_e  = m_busy(cyc);
    red_eff = red && !busy_e;
    flush_e = red_eff || (cyc - last_red < FLUSH_CYCLES);
    haz     = o.v && (needs_stall(o.rs1, o.u1, cyc) || needs_stall(o.rs2, o.u2, cyc));
    stall_e = busy_e || (haz && !flush_e);
    bub_e   = !busy_e && (haz || flush_e);
    check("stall_if",  32'(stall_if),    32'(stall_e));
    check("stall_id",  32'(stall_id),    32'(stall_e));
    check("bubble_ex", 32'(bubble_ex),   32'(bub_e));
    check("flush_id",  32'(flush_id),    32'(flush_e));
    check("busy",      32'(busy),        32'(busy_e));
    check("fwd1",      32'(fwd_rs1_sel), 32'(m_fwd1));
    check("fwd2",      32'(fwd_rs2_sel), 32'(m_fwd2));
    cnt_stall += int'(stall_id);
    cnt_busy  += int'(busy);
    cnt_flush += int'(flush_id);
    adv = o.v && !stall_e && !flush_e;
    if (red_eff) last_red = cyc;
    if (adv) begin
      if (FWD) begin
        m_fwd1 = fwd_src(o.rs1, o.u1, cyc);
        m_fwd2 = fwd_src(o.rs2, o.u2, cyc);
      end
      fl.push_back('{start: cyc + 1, len: (o.mc && o.mcc > 1) ? int'(o.mcc) : 1,
                     rd: o.rd, we: o.we, ld: o.ld});
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = fl.size() - 1; i >= 0; i--)
      if (fl[i].start + fl[i].len + 1 < cyc) fl.delete(i);
  endtask

  task automatic issue(input op_t o);
    bit adv;
    int tries = 0;
    do begin
      step(o, 1'b0, adv);
      tries++;
    end while (!adv && tries < 30);
    check("issue_taken", 32'(adv), 32'd1);
  endtask

  task automatic idle(input int n);
    op_t nop;
    bit  adv;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop.v = 1'b0;
    repeat (n) step(nop, 1'b0, adv);
  endtask

  task automatic clear_counts();
    cnt_stall = 0;
    cnt_busy  = 0;
    cnt_flush = 0;
  endtask

  initial begin
    op_t cur;
    bit  adv, red;
    model_reset();
    clear_counts();
    cyc = 0;

    // Reset holds every output low even with an active redirect and a hazard-looking ID.
    rst = 1'b1;
    drive(mk(5, 5, 1, 5, 1, 1, 1, 1, 4), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    idle(2);

    // Back-to-back ALU dependency on rs1.
    clear_counts();
    issue(mk(5, 1, 1, 2, 1, 1, 0, 0, 0));
    issue(mk(6, 5, 1, 0, 1, 1, 0, 0, 0));
    check("alu_dep_fwd1", 32'(fwd_rs1_sel), FWD ? 32'd1 : 32'd0);
    check("alu_dep_fwd2", 32'(fwd_rs2_sel), 32'd0);
    idle(3);
    check("alu_dep_stalls", 32'(cnt_stall), FWD ? 32'd0 : 32'd2);

    // Load-use on both operands.
    clear_counts();
    issue(mk(7, 1, 1, 0, 0, 1, 1, 0, 0));
    issue(mk(8, 7, 1, 7, 1, 1, 0, 0, 0));
    check("load_use_fwd1", 32'(fwd_rs1_sel), FWD ? 32'd2 : 32'd0);
    check("load_use_fwd2", 32'(fwd_rs2_sel), FWD ? 32'd2 : 32'd0);
    idle(3);
    check("load_use_stalls", 32'(cnt_stall), FWD ? 32'd1 : 32'd2);

    // x0 producer never matches.
    clear_counts();
    issue(mk(0, 1, 1, 2, 1, 1, 0, 0, 0));
    issue(mk(9, 0, 1, 0, 1, 1, 0, 0, 0));
    check("x0_fwd1", 32'(fwd_rs1_sel), 32'd0);
    idle(3);
    check("x0_stalls", 32'(cnt_stall), 32'd0);

    // Four-cycle multi-cycle op followed by a dependent add.
    clear_counts();
    issue(mk(9, 1, 1, 2, 1, 1, 0, 1, 4));
    issue(mk(10, 9, 1, 0, 0, 1, 0, 0, 0));
    check("mc_dep_fwd1", 32'(fwd_rs1_sel), FWD ? 32'd1 : 32'd0);
    idle(3);
    check("mc_busy_cycles", 32'(cnt_busy), 32'd3);
    check("mc_stalls", 32'(cnt_stall), FWD ? 32'd3 : 32'd5);

    // Redirect coinciding with a load-use match.
    clear_counts();
    issue(mk(11, 1, 1, 0, 0, 1, 1, 0, 0));
    step(mk(12, 11, 1, 0, 0, 1, 0, 0, 0), 1'b1, adv);
    idle(3);
    check("redir_stalls", 32'(cnt_stall), 32'd0);
    check("redir_flush_cycles", 32'(cnt_flush), 32'(FLUSH_CYCLES));

    // Multi-cycle counts of 0 and 1 behave as single-cycle ops.
    clear_counts();
    issue(mk(13, 1, 1, 0, 0, 1, 0, 1, 0));
    issue(mk(14, 13, 1, 0, 0, 1, 0, 1, 1));
    issue(mk(15, 14, 1, 13, 1, 1, 0, 0, 0));
    idle(3);
    check("mc_short_busy", 32'(cnt_busy), 32'd0);

    // Reset asserted during the second cycle of a multi-cycle op.
    issue(mk(3, 1, 1, 0, 0, 1, 0, 1, 4));
    step(mk(4, 3, 1, 0, 0, 1, 0, 0, 0), 1'b0, adv);
    drive(mk(4, 3, 1, 0, 0, 1, 0, 0, 0), 1'b0);
    #1;
    check("mc2_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    model_reset();
    issue(mk(4, 3, 1, 0, 0, 1, 0, 0, 0));
    idle(3);

    // Random traffic; redirects only while no multi-cycle op holds EX.
    cur = rnd_op();
    for (int i = 0; i < 400; i++) begin
      red = !m_busy(cyc) && ($urandom_range(0, 9) == 0);
      step(cur, red, adv);
      if (adv || red || $urandom_range(0, 3) == 0) cur = rnd_op();
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
